stream_mux_rr: RTL
==================

Name: stream_mux_rr

Overview:
- N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Generalises the datapath 2:1 select mux to any channel count, data width and select mode.
- Mode 0 routes the channel named by addr. Mode 1 arbitrates round-robin among the valid channels.
- One output register, so a path through the block takes 1 cycle. Sits between producer units and a shared consumer such as a writeback or memory port.

Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels (N >= 2).
- SELW, $clog2(N), width of addr and out_chan.
- MODE, 0, 0 = explicit select via addr, 1 = round-robin arbitration (addr ignored).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- addr  input  SELW  channel select (MODE 0 only).
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready (combinational).
- out_data  output  WIDTH  registered data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_chan  output  SELW  index of the channel that supplied out_data.

Behaviour:
- Reset (asynchronous, on reset=1 at any time, including mid-transfer):
  - out_valid=0, out_data=0, out_chan=0.
  - RR pointer last=N-1, so channel 0 has first priority after reset.
  - A word held in the output register is discarded.
- Output register:
  - can_accept = !out_valid | out_ready (drain and refill in the same cycle is allowed).
  - An input transfer for channel i occurs when in_valid[i] & in_ready[i] at the rising edge. On the next cycle: out_data = that channel's data, out_chan = i, out_valid = 1.
  - If out_valid & out_ready and no input transfer occurs, out_valid goes to 0. out_data and out_chan hold their values.
  - While out_valid & !out_ready: out_data, out_chan and out_valid stay stable; all in_ready = 0.
- MODE 0:
  - in_ready[addr] = can_accept; every other in_ready bit is 0.
  - If addr >= N, all in_ready = 0 and nothing is accepted.
  - Changing addr while the output is stalled has no effect on the held word.
- MODE 1:
  - grant = first i with in_valid[i], searched circularly from last+1 to last+N (mod N).
  - in_ready = one-hot(grant) & can_accept when any in_valid is set, else 0.
  - in_ready never depends on out_data.
  - On a transfer, last <= grant. With no transfer, last holds.
  - A single persistently valid channel is granted every accepting cycle.
  - With all N channels valid and out_ready=1, grants cycle 0,1,...,N-1,0,...
- Throughput: 1 word/cycle when out_ready is held at 1.
- At most one in_ready bit is high in any cycle.
- No combinational path from in_valid to out_valid. There is a combinational path from out_ready to in_ready.

Test Plan:
- Reset: assert reset mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 immediately, before the next clock edge.
- MODE 0, N=4, WIDTH=32, out_ready=1: in_data ch0..3 = FFFF, AB32, 72C4, 0DC2, all valid; addr=0,1,2,3 on consecutive cycles -> out_data = FFFF, AB32, 72C4, 0DC2 and out_chan = 0,1,2,3, each one cycle after its addr.
- MODE 0 stall: addr=1, in_valid=4'b0010, out_ready=0 for 3 cycles -> out_valid=1, out_data=AB32 stable and in_ready=0 throughout; raise out_ready -> word drains, and the next ch1 word appears the following cycle with no bubble.
- MODE 0 illegal select: N=3, addr=3 -> in_ready=3'b000, out_valid stays 0.
- MODE 1, N=4, all valid, out_ready=1 from reset -> out_chan sequence 0,1,2,3,0,1. With in_valid=4'b1010 -> out_chan alternates 1,3,1,3.
- MODE 1 fairness under backpressure: ch0 and ch2 valid, out_ready toggles 1,0,1,0 -> accepts alternate 0,2,0,2; last updates only on transfer cycles; no channel is granted twice in a row while the other is valid.

Source files
------------

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N producers, the stream mux and one consumer.
// The slave modport is the mux view; master is the producer/consumer side.
interface stream_mux_rr_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = $clog2(N)
);
  logic [SELW-1:0]    addr;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_chan;

  modport slave (
    input  addr, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );

  modport master (
    output addr, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );
endinterface

// File: rtl/stream_mux_rr.sv
// Registered N:1 stream multiplexer with valid/ready handshakes.
// MODE 0 routes the addressed channel; MODE 1 arbitrates round-robin.
module stream_mux_rr #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = $clog2(N),
  parameter int unsigned MODE  = 0
) (
  input  logic           clk,
  input  logic           reset,
  stream_mux_rr_if.slave bus
);
  logic             can_accept_c;
  logic             any_valid_c;
  logic             sel_ok_c;
  logic             xfer_c;
  logic             found_c;
  logic [SELW-1:0]  idx_c;
  logic [SELW-1:0]  grant_c;
  logic [SELW-1:0]  sel_c;
  logic [N-1:0]     in_ready_c;
  logic [WIDTH-1:0] chan_data_c [N];

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  last_q, last_d;

  for (genvar i = 0; i < int'(N); i++) begin : g_chan
    assign chan_data_c[i] = bus.in_data[i*WIDTH +: WIDTH];
  end

  assign can_accept_c = !out_valid_q || bus.out_ready;
  assign any_valid_c  = |bus.in_valid;

  // First valid channel after the previous grant, searched circularly.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    grant_c = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx_c = SELW'((32'(last_q) + k) % N);
      if (!found_c && bus.in_valid[idx_c]) begin
        grant_c = idx_c;
        found_c = 1'b1;
      end
    end
  end

  // Out-of-range addresses leave every ready low.
  always_comb begin
    sel_c      = (MODE == 1) ? grant_c : bus.addr;
    sel_ok_c   = (MODE == 1) ? any_valid_c : (32'(bus.addr) < N);
    in_ready_c = '0;
    if (sel_ok_c && can_accept_c) begin
      in_ready_c[sel_c] = 1'b1;
    end
  end

  assign xfer_c = |(bus.in_valid & in_ready_c);

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (xfer_c) begin
      out_data_d  = chan_data_c[sel_c];
      out_chan_d  = sel_c;
      out_valid_d = 1'b1;
      last_d      = sel_c;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pointer resets to N-1 so channel 0 wins the first arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= SELW'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;
endmodule
